// File: rtl/ps2_device_tx.sv
// ---------------------------------------------------------------------------
// ps2_device_tx
//   Device-side PS/2 transmitter (keyboard model). Scan-code bytes are queued
//   in a small FIFO and each is sent as an 11-bit PS/2 frame:
//   start(0), 8 data bits LSB first, odd parity, stop(1).
//
//   Handshake: a byte is accepted on any clk edge where in_valid and in_ready
//   are both high. in_valid may be held while in_ready is low; the byte is
//   taken on the first edge with in_ready high. in_ready does not depend on
//   in_valid.
//
// Ports
//   clk         in   system clock
//   resetn      in   synchronous, active-low reset
//   in_data     in   [7:0] scan-code byte to send
//   in_valid    in   in_data valid
//   in_ready    out  FIFO can accept (fifo_count < FIFO_DEPTH)
//   inhibit     in   host inhibit; blocks new frames, aborts a frame in flight
//   ps2_clk     out  PS/2 clock, idle high
//   ps2_data    out  PS/2 data, idle high
//   busy        out  high whenever the FSM is not IDLE
//   fifo_count  out  bytes queued, including the byte in flight
//   state_dbg   out  [1:0] current FSM state (IDLE=0, BIT_HI=1, BIT_LO=2, GAP=3)
// ---------------------------------------------------------------------------
module ps2_device_tx #(
    parameter int CLK_DIV    = 16,
    parameter int GAP_CYCLES = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          inhibit,
    output logic                          ps2_clk,
    output logic                          ps2_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic [1:0]                    state_dbg
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int GW = $clog2(GAP_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BIT_HI = 2'd1;
    localparam logic [1:0] BIT_LO = 2'd2;
    localparam logic [1:0] GAP    = 2'd3;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next;
    logic [7:0]    head;
    logic          push;
    logic          pop;

    logic [1:0]    state;
    logic [DW-1:0] div_cnt;
    logic [GW-1:0] gap_cnt;
    logic [3:0]    bit_idx;
    logic [10:0]   shift;

    assign head       = mem[rd_ptr];
    assign push       = in_valid & in_ready;
    // The head leaves the FIFO only once its stop bit has been fully sent.
    assign pop        = (state == BIT_LO) && !inhibit && (div_cnt == DIV_LAST) &&
                        (bit_idx == 4'd10);
    assign fifo_count = count;
    assign state_dbg  = state;

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count    <= count_next;
            // Registered from the next count, so a full FIFO shows not-ready
            // even in a cycle where the head is being popped.
            in_ready <= (count_next < FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= IDLE;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            bit_idx  <= '0;
            shift    <= '1;
        end else begin
            case (state)
                IDLE: begin
                    if ((count != '0) && !inhibit) begin
                        // Frame is {stop, parity, data, start}; bit 0 goes out first.
                        shift    <= {1'b1, ~^head, head, 1'b0};
                        bit_idx  <= '0;
                        div_cnt  <= '0;
                        state    <= BIT_HI;
                        busy     <= 1'b1;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b0;
                    end
                end
                BIT_HI: begin
                    if (inhibit) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= BIT_LO;
                        ps2_clk <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                BIT_LO: begin
                    if (inhibit) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        ps2_clk  <= 1'b1;
                        ps2_data <= 1'b1;
                    end else if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        ps2_clk <= 1'b1;
                        if (bit_idx != 4'd10) begin
                            // Next bit is driven as ps2_clk rises so it is
                            // stable for a full high phase before the fall.
                            bit_idx  <= bit_idx + 1'b1;
                            shift    <= {1'b1, shift[10:1]};
                            ps2_data <= shift[1];
                            state    <= BIT_HI;
                        end else begin
                            ps2_data <= 1'b1;
                            gap_cnt  <= '0;
                            state    <= GAP;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    ps2_clk  <= 1'b1;
                    ps2_data <= 1'b1;
                end
            endcase
        end
    end

endmodule
